// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU boot loader: loader states,
// word/byte widths and the image framing sizes.
package hack_pkg;

  localparam int WORD_W    = 16;
  localparam int BYTE_W    = 8;
  localparam int LEN_W     = 16;
  localparam int LEN_BYTES = 2;

  // Image layout: LEN_HI, LEN_LO, N x {DATA_HI, DATA_LO}, CKSUM.
  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CKSUM   = 3'd4,
    RELEASE = 3'd5,
    RUN     = 3'd6,
    ERROR   = 3'd7
  } loader_state_e;

  // States that consume image bytes; also the states reported as loading.
  function automatic logic takes_bytes(input loader_state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CKSUM);
  endfunction

endpackage

// File: rtl/hack_release_timer.sv
// Count-down timer holding the CPU in reset after a good checksum; expire is
// high during the last of RELEASE_DELAY cycles following a load pulse.
module hack_release_timer #(
  parameter int RELEASE_DELAY = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam int CNT_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RELEASE_DELAY - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (load) begin
      active_d = 1'b1;
      cnt_d    = LOAD_VAL;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign expire = active_q && (cnt_q == '0);

endmodule

// File: rtl/hack_boot_loader.sv
// Boot sequencer for the Hack CPU: receives a length-prefixed, checksummed
// image over a byte stream, writes it into instruction ROM, then releases reset.
module hack_boot_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W        = 15,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [BYTE_W-1:0]   rx_data,
  output logic                rx_ready,
  input  logic                load_req,
  output logic                rom_we,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [WORD_W-1:0]   rom_wdata,
  output logic                cpu_reset,
  output logic                loading,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     words_loaded,
  output loader_state_e       state_dbg
);

  // Handshake: a byte transfers on the rising edge where rx_valid && rx_ready.
  // rx_ready depends only on state and reset, never on rx_valid; gaps hold state.

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  loader_state_e       state_q, state_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic                rom_we_q, rom_we_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [WORD_W-1:0]   rom_wdata_q, rom_wdata_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                cpu_reset_q, cpu_reset_d;

  logic                accept;
  logic                timer_load;
  logic                timer_expire;
  logic [LEN_W-1:0]    len_in;
  logic [ADDR_W:0]     count_next;

  assign rx_ready   = !reset && takes_bytes(state_q);
  assign accept     = rx_valid && rx_ready;
  assign len_in     = {len_q[LEN_W-1:BYTE_W], rx_data};
  assign count_next = words_q + (ADDR_W+1)'(1);

  hack_release_timer #(
    .RELEASE_DELAY (RELEASE_DELAY)
  ) u_release_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (timer_load),
    .expire (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    len_d       = len_q;
    hi_d        = hi_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    words_d     = words_q;
    timer_load  = 1'b0;

    unique case (state_q)
      LEN_HI: begin
        if (accept) begin
          len_d   = {rx_data, len_q[BYTE_W-1:0]};
          sum_d   = sum_q + rx_data;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = len_in;
          sum_d = sum_q + rx_data;
          if (32'(len_in) > MAX_WORDS) begin
            state_d = ERROR;
          end else if (len_in == '0) begin
            state_d = CKSUM;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        // The word index is the count of words already written this image.
        if (accept) begin
          sum_d       = sum_q + rx_data;
          rom_we_d    = 1'b1;
          rom_addr_d  = words_q[ADDR_W-1:0];
          rom_wdata_d = {hi_q, rx_data};
          words_d     = count_next;
          state_d     = (32'(count_next) == 32'(len_q)) ? CKSUM : DATA_HI;
        end
      end
      CKSUM: begin
        if (accept) begin
          if (rx_data == sum_q) begin
            state_d    = RELEASE;
            timer_load = 1'b1;
          end else begin
            state_d = ERROR;
          end
        end
      end
      RELEASE: begin
        if (timer_expire) begin
          state_d = RUN;
        end
      end
      RUN, ERROR: begin
        if (load_req) begin
          state_d    = LEN_HI;
          sum_d      = '0;
          words_d    = '0;
          rom_addr_d = '0;
        end
      end
      default: state_d = LEN_HI;
    endcase

    cpu_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LEN_HI;
      sum_q       <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      words_q     <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      words_q     <= words_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign rom_we       = rom_we_q;
  assign rom_addr     = rom_addr_q;
  assign rom_wdata    = rom_wdata_q;
  assign words_loaded = words_q;
  assign cpu_reset    = cpu_reset_q;
  assign loading      = takes_bytes(state_q);
  assign done         = (state_q == RUN);
  assign error        = (state_q == ERROR);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Testbench for hack_boot_loader: image streams with a byte-level reference
// model, a ROM-write scoreboard and release-timing checks.
module tb_hack_boot_loader;
  import hack_pkg::*;

  localparam int ADDR_W        = 15;
  localparam int RELEASE_DELAY = 4;
  localparam int W             = (ADDR_W + 1) + ADDR_W + WORD_W;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                rx_valid = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_ready;
  logic                load_req = 1'b0;
  logic                rom_we;
  logic [ADDR_W-1:0]   rom_addr;
  logic [WORD_W-1:0]   rom_wdata;
  logic                cpu_reset;
  logic                loading;
  logic                done;
  logic                error;
  logic [ADDR_W:0]     words_loaded;
  loader_state_e       state_dbg;

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_rd = 0;
  logic [7:0]   img_q[$];
  bit           m_pass;
  bit           m_oversize;
  int           m_n;
  bit           drv_ok;

  hack_boot_loader #(
    .ADDR_W        (ADDR_W),
    .RELEASE_DELAY (RELEASE_DELAY)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .load_req     (load_req),
    .rom_we       (rom_we),
    .rom_addr     (rom_addr),
    .rom_wdata    (rom_wdata),
    .cpu_reset    (cpu_reset),
    .loading      (loading),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // ROM write monitor: records {words_loaded, addr, data} for every strobe.
  always @(negedge clock) begin
    if (!reset && rom_we) obs_q.push_back({words_loaded, rom_addr, rom_wdata});
  end

  // ---------------- reference model ----------------
  // Decodes an image from the byte list: length, expected writes, checksum verdict.
  task automatic model_image();
    int s;
    m_n        = int'(img_q[0]) * 256 + int'(img_q[1]);
    m_oversize = (m_n > (1 << ADDR_W));
    m_pass     = 1'b0;
    if (!m_oversize) begin
      s = 0;
      for (int i = 0; i < 2 + 2 * m_n; i++) s = s + int'(img_q[i]);
      for (int i = 0; i < m_n; i++)
        exp_q.push_back({(ADDR_W+1)'(i + 1), ADDR_W'(i), img_q[2+2*i], img_q[3+2*i]});
      m_pass = (int'(img_q[2 + 2 * m_n]) == (s % 256));
    end
  endtask

  task automatic build_image(input int n, input int cksum_delta);
    int s;
    img_q.delete();
    img_q.push_back(8'(n / 256));
    img_q.push_back(8'(n % 256));
    for (int i = 0; i < 2 * n; i++) img_q.push_back(8'($urandom_range(0, 255)));
    s = 0;
    foreach (img_q[i]) s = s + int'(img_q[i]);
    img_q.push_back(8'((s + cksum_delta) % 256));
  endtask

  task automatic image1(input logic [7:0] last);
    img_q.delete();
    img_q.push_back(8'h00); img_q.push_back(8'h02);
    img_q.push_back(8'h00); img_q.push_back(8'h05);
    img_q.push_back(8'hEA); img_q.push_back(8'h87);
    img_q.push_back(last);
  endtask

  // ---------------- drivers ----------------
  // Offers one byte; returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    while (!rx_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    tests++;
    if (!rx_ready) begin
      failed++;
      $display("FAIL rx_ready_timeout byte=%h got rx_ready=%b exp=1", b, rx_ready);
      drv_ok   = 1'b0;
      rx_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 random idle cycles, 2 one idle cycle per byte.
  task automatic drive_image(input int gap_mode);
    int nb;
    int g;
    model_image();
    nb     = m_oversize ? LEN_BYTES : img_q.size();
    drv_ok = 1'b1;
    for (int i = 0; i < nb && drv_ok; i++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? int'($urandom_range(0, 2)) : 1;
      repeat (g) begin @(posedge clock); #1; end
      send_byte(img_q[i]);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clock);
    #1;
    load_req = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_drain(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_rd >= obs_q.size()) begin
        failed++;
        $display("FAIL %s_write got=none exp=%h", tag, e);
      end else begin
        if (obs_q[obs_rd] !== e) begin
          failed++;
          $display("FAIL %s_write got=%h exp=%h", tag, obs_q[obs_rd], e);
        end
        obs_rd++;
      end
    end
    tests++;
    if (obs_q.size() != obs_rd) begin
      failed++;
      $display("FAIL %s_extra_writes got=%0d exp=%0d", tag, obs_q.size(), obs_rd);
      obs_rd = obs_q.size();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++; if (rx_ready !== 1'b0) begin failed++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
    tests++; if (cpu_reset !== 1'b1) begin failed++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
    tests++; if (rom_we !== 1'b0) begin failed++; $display("FAIL reset_rom_we got=%b exp=0", rom_we); end
    tests++; if (rom_addr !== '0 || rom_wdata !== '0) begin failed++; $display("FAIL reset_rom_bus got=%h/%h exp=0/0", rom_addr, rom_wdata); end
    tests++; if (words_loaded !== '0) begin failed++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
    tests++; if ({loading, done, error} !== 3'b100) begin failed++; $display("FAIL reset_status got=%b exp=100", {loading, done, error}); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    tests++; if (rx_ready !== 1'b1 || state_dbg !== LEN_HI) begin failed++; $display("FAIL post_reset_ready got=%b/%0d exp=1/LEN_HI", rx_ready, state_dbg); end
    @(posedge clock); #1;
  endtask

  task automatic test_good_image();
    bit exp_done;
    image1(8'h78);
    drive_image(0);
    tests++; if (!m_pass) begin failed++; $display("FAIL good_model_cksum got=0 exp=1"); end
    for (int k = 0; k <= RELEASE_DELAY; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      exp_done = (k == RELEASE_DELAY);
      tests++;
      if (done !== exp_done || cpu_reset !== !exp_done) begin
        failed++;
        $display("FAIL good_release_k%0d got done=%b cpu_reset=%b exp done=%b", k, done, cpu_reset, exp_done);
      end
    end
    tests++; if (words_loaded !== (ADDR_W+1)'(2)) begin failed++; $display("FAIL good_words got=%0d exp=2", words_loaded); end
    sb_drain("good");
  endtask

  task automatic test_bad_cksum();
    pulse_load();
    tests++; if (cpu_reset !== 1'b1 || loading !== 1'b1) begin failed++; $display("FAIL bad_reload got=%b/%b exp=1/1", cpu_reset, loading); end
    image1(8'h79);
    drive_image(0);
    tests++; if ({error, cpu_reset, rx_ready} !== 3'b110) begin failed++; $display("FAIL bad_error got=%b exp=110", {error, cpu_reset, rx_ready}); end
    rx_valid = 1'b1;
    rx_data  = 8'h78;
    repeat (3) begin @(posedge clock); #1; end
    rx_valid = 1'b0;
    tests++; if ({error, cpu_reset, done} !== 3'b110) begin failed++; $display("FAIL bad_hold got=%b exp=110", {error, cpu_reset, done}); end
    sb_drain("bad");
    pulse_load();
    tests++; if ({loading, error} !== 2'b10 || words_loaded !== '0 || rom_addr !== '0) begin
      failed++; $display("FAIL bad_recover got=%b words=%0d addr=%0d exp=10 0 0", {loading, error}, words_loaded, rom_addr);
    end
  endtask

  task automatic test_oversize();
    img_q.delete();
    img_q.push_back(8'h80); img_q.push_back(8'h01);
    drive_image(0);
    tests++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin failed++; $display("FAIL oversize_error got=%b/%b exp=1/1", error, cpu_reset); end
    repeat (3) begin @(posedge clock); #1; end
    sb_drain("oversize");
    pulse_load();
    send_byte(8'h80);
    send_byte(8'h00);
    tests++; if (error !== 1'b0 || state_dbg !== DATA_HI) begin failed++; $display("FAIL max_len_accept got=%b/%0d exp=0/DATA_HI", error, state_dbg); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    tests++; if (state_dbg !== LEN_HI) begin failed++; $display("FAIL max_len_abort got=%0d exp=LEN_HI", state_dbg); end
    sb_drain("max_len");
  endtask

  task automatic test_empty();
    bit exp_done;
    img_q.delete();
    repeat (3) img_q.push_back(8'h00);
    drive_image(0);
    for (int k = 0; k <= RELEASE_DELAY; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      exp_done = (k == RELEASE_DELAY);
      tests++;
      if (done !== exp_done || cpu_reset !== !exp_done) begin
        failed++;
        $display("FAIL empty_release_k%0d got done=%b cpu_reset=%b exp done=%b", k, done, cpu_reset, exp_done);
      end
    end
    tests++; if (words_loaded !== '0) begin failed++; $display("FAIL empty_words got=%0d exp=0", words_loaded); end
    sb_drain("empty");
  endtask

  task automatic test_reset_mid();
    pulse_load();
    exp_q.push_back({(ADDR_W+1)'(1), ADDR_W'(0), 16'h1234});
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h56);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    tests++; if (state_dbg !== LEN_HI || words_loaded !== '0 || cpu_reset !== 1'b1 || rom_we !== 1'b0) begin
      failed++; $display("FAIL midreset_state got=%0d words=%0d cpu_reset=%b we=%b exp=LEN_HI 0 1 0", state_dbg, words_loaded, cpu_reset, rom_we);
    end
    sb_drain("midreset");
    image1(8'h78);
    drive_image(1);
    repeat (RELEASE_DELAY) begin @(posedge clock); #1; end
    tests++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin failed++; $display("FAIL midreset_resend got=%b/%b exp=1/0", done, cpu_reset); end
    sb_drain("resend");
  endtask

  task automatic test_stall_reload();
    pulse_load();
    image1(8'h78);
    drive_image(2);
    repeat (RELEASE_DELAY) begin @(posedge clock); #1; end
    tests++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin failed++; $display("FAIL stall_run got=%b/%b exp=1/0", done, cpu_reset); end
    sb_drain("stall");
    load_req = 1'b1;
    @(posedge clock); #1;
    load_req = 1'b0;
    tests++; if ({cpu_reset, loading, done} !== 3'b110) begin failed++; $display("FAIL run_reload got=%b exp=110", {cpu_reset, loading, done}); end
  endtask

  task automatic test_random();
    int n;
    int delta;
    for (int it = 0; it < 6; it++) begin
      if (done || error) pulse_load();
      n     = $urandom_range(1, 6);
      delta = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0;
      build_image(n, delta);
      drive_image(1);
      if (m_pass) repeat (RELEASE_DELAY) begin @(posedge clock); #1; end
      tests++;
      if (m_pass ? (done !== 1'b1 || cpu_reset !== 1'b0) : (error !== 1'b1 || cpu_reset !== 1'b1)) begin
        failed++;
        $display("FAIL rand%0d_outcome got done=%b error=%b cpu_reset=%b exp pass=%b", it, done, error, cpu_reset, m_pass);
      end
      tests++; if (words_loaded !== (ADDR_W+1)'(m_n)) begin failed++; $display("FAIL rand%0d_words got=%0d exp=%0d", it, words_loaded, m_n); end
      sb_drain("rand");
    end
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_bad_cksum();
    test_oversize();
    test_empty();
    test_reset_mid();
    test_stall_reload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
